hamming_mem_engine: RTL and testbench
=====================================

# hamming_mem_engine

- Parametrised hardware SECDED (16,11) Hamming engine that walks data memory.
- Encode mode: reads MSG_COUNT 11-bit messages from SRC_BASE and writes 16-bit codewords with parity inserted to DST_BASE.
- Decode mode: reads codewords, corrects single-bit errors, flags double-bit errors, and writes recovered messages with status.
- Sits beside the data memory as a self-contained program-1/program-2 accelerator, driven by a start/done handshake and owning the memory port while busy.

## Interface
- MSG_COUNT, 15, number of messages processed per run (1..127).
- SRC_BASE, 0, byte address of first source word (low byte).
- DST_BASE, 30, byte address of first destination word (low byte).
- ADDR_W, 8, memory address width.
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE or DONE.
- mode  in  1  0 = encode, 1 = decode; captured on accepted start.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  high in DONE; held until the next accepted start.
- mem_addr  out  ADDR_W  byte address to data memory.
- mem_wr_en  out  1  write strobe.
- mem_wr_data  out  8  write byte.
- mem_rd_data  in  8  read byte; valid one cycle after mem_addr (synchronous read).
- err_single_cnt  out  8  decode: count of corrected words this run.
- err_double_cnt  out  8  decode: count of double-error words this run.

## Operation
- Word i occupies two bytes: low byte at base+2i, high byte at base+2i+1.
- Encode input: high = {5'b0, d[11:9]}, low = d[8:1].
- Codeword bit k equals Hamming position k, giving cw[15:0] = {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}:
  - p8 = ^d[11:5]
  - p4 = ^{d11..d8, d4..d2}
  - p2 = ^{d11, d10, d7, d6, d4, d3, d1}
  - p1 = ^{d11, d9, d7, d5, d4, d2, d1}
  - p0 = ^(cw[15:1]), i.e. even overall parity.
- Decode:
  - Syndrome s[3:0] = {p8,p4,p2,p1 recomputed from received data} ^ received {p8,p4,p2,p1}.
  - Overall parity q = ^cw[15:0].
  - q=0, s=0: clean, status 00.
  - q=1: single error; flip cw[s] (s=0 means p0 itself), status 01, err_single_cnt++.
  - q=0, s≠0: double error; data left uncorrected, status 10, err_double_cnt++.
  - Output high = {status[1:0], 3'b0, d[11:9]}, low = d[8:1].
- Counters saturate at 255 and are cleared on accepted start. In encode mode they stay 0.
- FSM: IDLE → RD_LO → RD_HI → CALC → WR_LO → WR_HI → (RD_LO for the next word, or DONE); DONE → RD_LO on start.
  - RD_LO: addr = SRC+2i.
  - RD_HI: addr = SRC+2i+1, capture low byte.
  - CALC: capture high byte, compute result into a 16-bit register; no memory access.
  - WR_LO: write low byte to DST+2i.
  - WR_HI: write high byte to DST+2i+1; if i = MSG_COUNT-1 go to DONE, else i++.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. Overlapping source and destination regions are permitted; each word is fully read before it is written.
- start while busy is ignored. mode changes while busy are ignored.

## Timing
- Reset values: busy=0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, both counters 0, state IDLE, i=0.
- Reset is asynchronous, so writes stop immediately. Any partially written word is left as-is.
- start accepted at edge T: RD_LO is active during cycle T+1.
- Each word takes exactly 5 cycles. done rises at edge T+5·MSG_COUNT+1.
- mem_wr_en is high only in WR_LO and WR_HI. mem_addr and mem_wr_data are registered, valid in the same cycle as the strobe.
- In DONE, a start and a done-hold coinciding resolves as: done drops and the new run starts.

## Test plan
- Encode 0x000 and 0x7FF (MSG_COUNT=2) → memory at DST holds 0x00,0x00,0xFF,0xFF; done at exactly cycle 11 after start.
- Encode 15 random messages → each codeword matches the parity equations above; counters stay 0.
- Decode 0xFFFF with bit 5 flipped (0xFFDF) → low 0xFF, high 0x47, err_single_cnt=1.
- Decode 0xFDDF (bits 5 and 9 flipped) → low 0xED, high 0x87, err_double_cnt=1; 0xFFFF → high 0x07, low 0xFF.
- Decode with p0-only error (0xFFFE) → status 01, data 0x7FF unchanged.
- Assert reset (low) mid-run at word 3 → outputs return to reset values at once, no further writes; a new start then completes a full run with done at the expected cycle.

Source files
------------

// File: rtl/hamming_mem_engine.sv
// SECDED (16,11) Hamming engine that walks a byte-wide data memory, encoding
// messages into codewords or decoding codewords into messages plus status.
module hamming_mem_engine #(
  parameter int MSG_COUNT = 15,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 30,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        err_single_cnt,
  output logic [7:0]        err_double_cnt
);

  localparam int IDX_W = 7;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MSG_COUNT - 1);
  localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, CALC, WR_LO, WR_HI, DONE} state_t;
  typedef enum logic [1:0] {ST_CLEAN = 2'b00, ST_SINGLE = 2'b01, ST_DOUBLE = 2'b10} status_t;

  // {p8, p4, p2, p1} over data bits d[11:1].
  function automatic logic [3:0] parity_bits(input logic [11:1] d);
    return {^d[11:5],
            ^{d[11:8], d[4:2]},
            ^{d[11], d[10], d[7], d[6], d[4], d[3], d[1]},
            ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]}};
  endfunction

  function automatic logic [15:0] hamming_encode(input logic [11:1] d);
    logic [3:0]  p;
    logic [15:1] body;
    p    = parity_bits(d);
    body = {d[11:5], p[3], d[4:2], p[2], d[1], p[1], p[0]};
    return {body, ^body};
  endfunction

  // Hamming position that carries data bit d[k].
  function automatic logic [3:0] data_pos(input logic [3:0] k);
    case (k)
      4'd1:    return 4'd3;
      4'd2:    return 4'd5;
      4'd3:    return 4'd6;
      4'd4:    return 4'd7;
      default: return k + 4'd4;
    endcase
  endfunction

  state_t           state;
  logic             launch;
  logic             mode_q;
  logic [IDX_W-1:0] idx;
  logic [7:0]       lo_byte;
  logic [7:0]       result_hi;

  logic [ADDR_W-1:0] off_cur;
  logic [ADDR_W-1:0] off_nxt;
  logic [15:0]       rx_word;
  logic [11:1]       rx_data;
  logic [11:1]       fix_data;
  logic [3:0]        syndrome;
  logic              overall;
  status_t           status;
  logic [15:0]       enc_word;
  logic [15:0]       result_nxt;

  assign off_cur = ADDR_W'({idx, 1'b0});
  assign off_nxt = ADDR_W'({idx + IDX_W'(1), 1'b0});

  // The high byte arrives on mem_rd_data during CALC; the low byte was captured in RD_HI.
  // NOTE: every always_comb output gets a value on every path (defaults first), otherwise a latch is inferred.
  always_comb begin
    rx_word  = {mem_rd_data, lo_byte};
    rx_data  = {rx_word[15:9], rx_word[7:5], rx_word[3]};
    syndrome = parity_bits(rx_data) ^ {rx_word[8], rx_word[4], rx_word[2], rx_word[1]};
    overall  = ^rx_word;
    fix_data = rx_data;
    for (int k = 1; k <= 11; k++) begin
      fix_data[k] = rx_data[k] ^ (overall && (syndrome == data_pos(4'(k))));
    end
    if (overall)             status = ST_SINGLE;
    else if (syndrome != '0) status = ST_DOUBLE;
    else                     status = ST_CLEAN;
    enc_word   = hamming_encode({mem_rd_data[2:0], lo_byte});
    result_nxt = mode_q ? {status, 3'b000, fix_data} : enc_word;
  end

  // An accepted start spends one launch cycle clearing run state before RD_LO.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      launch         <= 1'b0;
      mode_q         <= 1'b0;
      idx            <= '0;
      lo_byte        <= '0;
      result_hi      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_addr       <= '0;
      mem_wr_en      <= 1'b0;
      mem_wr_data    <= '0;
      err_single_cnt <= '0;
      err_double_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            launch   <= 1'b0;
            busy     <= 1'b1;
            mem_addr <= SRC_A;
            state    <= RD_LO;
          end else if (start) begin
            launch         <= 1'b1;
            mode_q         <= mode;
            done           <= 1'b0;
            idx            <= '0;
            err_single_cnt <= '0;
            err_double_cnt <= '0;
          end
        end
        RD_LO: begin
          mem_addr <= SRC_A + off_cur + ONE_A;
          state    <= RD_HI;
        end
        RD_HI: begin
          lo_byte <= mem_rd_data;
          state   <= CALC;
        end
        CALC: begin
          result_hi   <= result_nxt[15:8];
          mem_wr_data <= result_nxt[7:0];
          mem_addr    <= DST_A + off_cur;
          mem_wr_en   <= 1'b1;
          if (mode_q && status == ST_SINGLE && err_single_cnt != 8'hFF)
            err_single_cnt <= err_single_cnt + 8'd1;
          if (mode_q && status == ST_DOUBLE && err_double_cnt != 8'hFF)
            err_double_cnt <= err_double_cnt + 8'd1;
          state <= WR_LO;
        end
        WR_LO: begin
          mem_addr    <= DST_A + off_cur + ONE_A;
          mem_wr_data <= result_hi;
          state       <= WR_HI;
        end
        WR_HI: begin
          mem_wr_en <= 1'b0;
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx      <= idx + IDX_W'(1);
            mem_addr <= SRC_A + off_nxt;
            state    <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_mem_engine.sv
// Scoreboard bench for hamming_mem_engine: a positional Hamming model predicts
// every memory write; a negedge monitor pops and compares each DUT write.
module tb_hamming_mem_engine;

  localparam int N   = 4;
  localparam int SRC = 0;
  localparam int DST = 250;  // destination wraps past address 255 onto the source region
  localparam int AW  = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic          busy, done, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wr_data, mem_rd_data, err_single_cnt, err_double_cnt;

  logic [7:0] mem [256];
  logic       ld_en   = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;
  logic [15:0] src_words [N];
  int          exp_single, exp_double;

  hamming_mem_engine #(.MSG_COUNT(N), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .err_single_cnt(err_single_cnt), .err_double_cnt(err_double_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("write_expected", 32'(mem_wr_en), 32'd0);
      else begin
        mon_exp = exp_q.pop_front();
        check("write_addr_data", {16'd0, mem_addr, mem_wr_data}, {16'd0, mon_exp});
      end
    end
  end

  // Reference model: classic positional Hamming code, data at non-power-of-two positions.
  function automatic logic [15:0] ref_encode(input logic [10:0] msg);
    logic [15:0] cw;
    int          k;
    logic        x;
    cw = '0;
    k  = 0;
    for (int p = 1; p < 16; p++)
      if ((p & (p - 1)) != 0) begin cw[p] = msg[k]; k++; end
    for (int b = 1; b < 16; b = b * 2) begin
      x = 1'b0;
      for (int p = 1; p < 16; p++) if ((p & b) != 0 && p != b) x ^= cw[p];
      cw[b] = x;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] ref_data(input logic [15:0] cw);
    logic [10:0] msg;
    int          k;
    msg = '0;
    k   = 0;
    for (int p = 1; p < 16; p++)
      if ((p & (p - 1)) != 0) begin msg[k] = cw[p]; k++; end
    return msg;
  endfunction

  function automatic logic [15:0] ref_decode(input logic [15:0] cw, output int status);
    int          syn;
    logic [15:0] fixed;
    syn = 0;
    for (int p = 1; p < 16; p++) if (cw[p]) syn ^= p;
    fixed = cw;
    if (^cw) begin fixed[syn] = ~fixed[syn]; status = 1; end
    else if (syn != 0) status = 2;
    else status = 0;
    return {2'(status), 3'b000, ref_data(fixed)};
  endfunction

  task automatic expect_run(input logic m);
    int          st;
    logic [15:0] r;
    exp_single = 0;
    exp_double = 0;
    for (int i = 0; i < N; i++) begin
      if (m) begin
        r = ref_decode(src_words[i], st);
        if (st == 1) exp_single++;
        if (st == 2) exp_double++;
      end else r = ref_encode(src_words[i][10:0]);
      exp_q.push_back({8'(DST + 2 * i), r[7:0]});
      exp_q.push_back({8'(DST + 2 * i + 1), r[15:8]});
    end
  endtask

  task automatic load_src();
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 2; b++) begin
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 8'(SRC + 2 * i + b);
        ld_data = (b == 1) ? src_words[i][15:8] : src_words[i][7:0];
      end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One run; reset_at != 0 pulls reset low that many cycles after the accepting edge.
  task automatic run(input logic m, input int reset_at);
    int cyc;
    load_src();
    expect_run(m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1 start = 1'b0;
    mode = ~m;
    for (cyc = 1; cyc <= 5 * N + 20; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) check("busy_rise", 32'(busy), 32'd1);
      if (cyc == 7) start = 1'b1;
      if (cyc == 8) start = 1'b0;
      if (reset_at != 0 && cyc == reset_at) begin
        #1 reset = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async_ctrl", {29'd0, busy, done, mem_wr_en}, 32'd0);
        check("rst_async_addr_data", {16'd0, mem_addr, mem_wr_data}, 32'd0);
        check("rst_async_counters", {16'd0, err_single_cnt, err_double_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        return;
      end
      if (done === 1'b1) break;
    end
    check("done_cycle", 32'(cyc), 32'(5 * N + 1));
    check("busy_fall", 32'(busy), 32'd0);
    check("err_single_cnt", 32'(err_single_cnt), 32'(exp_single));
    check("err_double_cnt", 32'(err_double_cnt), 32'(exp_double));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("done_hold", 32'(done), 32'd1);
  endtask

  function automatic logic [15:0] rand_msg();
    return 16'($urandom_range(0, 2047));
  endfunction

  initial begin
    int nflip, b1, b2;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {29'd0, busy, done, mem_wr_en}, 32'd0);
    check("reset_addr_data", {16'd0, mem_addr, mem_wr_data}, 32'd0);
    check("reset_counters", {16'd0, err_single_cnt, err_double_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    src_words[0] = 16'h0000;
    src_words[1] = 16'h07FF;
    src_words[2] = rand_msg();
    src_words[3] = rand_msg();
    run(1'b0, 0);
    check("enc_zero_ones", {mem[8'(DST)], mem[8'(DST + 1)], mem[8'(DST + 2)], mem[8'(DST + 3)]},
          32'h0000_FFFF);

    repeat (4) begin
      for (int i = 0; i < N; i++) src_words[i] = rand_msg();
      run(1'b0, 0);
    end

    src_words[0] = 16'hFFDF;
    src_words[1] = 16'hFDDF;
    src_words[2] = 16'hFFFF;
    src_words[3] = 16'hFFFE;
    run(1'b1, 0);
    check("dec_single_bit5", {16'd0, mem[8'(DST)], mem[8'(DST + 1)]}, 32'h0000_FF47);
    check("dec_double", {16'd0, mem[8'(DST + 2)], mem[8'(DST + 3)]}, 32'h0000_ED87);
    check("dec_clean", {16'd0, mem[8'(DST + 4)], mem[8'(DST + 5)]}, 32'h0000_FF07);
    check("dec_p0_only", {16'd0, mem[8'(DST + 6)], mem[8'(DST + 7)]}, 32'h0000_FF47);
    check("dec_counts", {16'd0, err_single_cnt, err_double_cnt}, 32'h0000_0201);

    repeat (4) begin
      for (int i = 0; i < N; i++) begin
        src_words[i] = ref_encode(11'($urandom_range(0, 2047)));
        nflip = $urandom_range(0, 2);
        b1    = $urandom_range(0, 15);
        b2    = (b1 + $urandom_range(1, 15)) % 16;
        if (nflip >= 1) src_words[i][b1] = ~src_words[i][b1];
        if (nflip == 2) src_words[i][b2] = ~src_words[i][b2];
      end
      run(1'b1, 0);
    end

    // Reset lands in WR_LO of the last word (word 3).
    for (int i = 0; i < N; i++) src_words[i] = rand_msg();
    run(1'b0, 5 * 3 + 4);
    for (int i = 0; i < N; i++) src_words[i] = rand_msg();
    run(1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
